// File: rtl/crypto_isa_pkg.sv
// Shared ISA definitions for the mini crypto processor: opcodes, widths and
// sequencer state encoding.
package crypto_isa_pkg;

  localparam int INSTR_W = 8;
  localparam int ADDR_W  = 4;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_LOAD = 4'h1;
  localparam logic [3:0] OP_XOR  = 4'h2;
  localparam logic [3:0] OP_ADD  = 4'h3;
  localparam logic [3:0] OP_ROTL = 4'h4;
  localparam logic [3:0] OP_SBOX = 4'h5;
  localparam logic [3:0] OP_JMP  = 4'h6;
  localparam logic [3:0] OP_JZ   = 4'h7;
  localparam logic [3:0] OP_HALT = 4'hF;

  typedef enum logic [3:0] {
    ST_IDLE   = 4'd0,
    ST_FETCH  = 4'd1,
    ST_DECODE = 4'd2,
    ST_EXEC   = 4'd3,
    ST_WAIT   = 4'd4,
    ST_WB     = 4'd5,
    ST_HALT   = 4'd6,
    ST_ERR    = 4'd7,
    ST_STEP   = 4'd8
  } seq_state_t;

  // Single-cycle ALU opcodes (NOP included: it still walks through EXEC/WB).
  function automatic logic is_alu_op(input logic [3:0] op);
    return (op <= OP_ROTL);
  endfunction

endpackage

// File: rtl/exec_timeout_ctr.sv
// Counts WAIT cycles for the S-box handshake; expired flags the cycle whose
// increment would reach TIMEOUT.
module exec_timeout_ctr #(
  parameter int TIMEOUT = 16,
  parameter int W       = 5
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [W-1:0] count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + 1'b1;
    end
  end

  assign expired = enable && (count == W'(TIMEOUT - 1));

endmodule

// File: rtl/crypto_seq_ctrl.sv
// Instruction sequencer: fetch/decode/execute/commit FSM driving PC, ALU and S-box.
// Optional CTRL_SINGLE_STEP_EN adds a step input and a STEP hold state after each commit.
module crypto_seq_ctrl #(
  parameter int ADDR_W       = 4,
  parameter int INSTR_W      = 8,
  parameter int EXEC_TIMEOUT = 16,
  parameter int TO_W         = 5
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic [INSTR_W-1:0]         instr,
  input  logic                       zero_flag,
  input  logic                       unit_done,
`ifdef CTRL_SINGLE_STEP_EN
  input  logic                       step,
`endif
  output logic                       pc_enable,
  output logic                       jump,
  output logic [ADDR_W-1:0]          jump_addr,
  output logic [3:0]                 alu_op,
  output logic [3:0]                 alu_operand,
  output logic                       alu_valid,
  output logic                       unit_start,
  output logic                       reg_we,
  output logic                       busy,
  output logic                       halted,
  output logic                       error,
  output crypto_isa_pkg::seq_state_t fsm_state
);
  import crypto_isa_pkg::*;

`ifdef CTRL_SINGLE_STEP_EN
  localparam seq_state_t COMMIT_ST = ST_STEP;
`else
  localparam seq_state_t COMMIT_ST = ST_FETCH;
`endif

  seq_state_t         state, state_nxt;
  logic [INSTR_W-1:0] ir;
  logic [3:0]         opcode, operand;
  logic               alu_valid_nxt, unit_start_nxt, reg_we_nxt;
  logic               pc_enable_nxt, jump_nxt;
  logic               ctr_clear, ctr_en, ctr_expired;

  assign opcode    = ir[INSTR_W-1 -: 4];
  assign operand   = ir[3:0];
  assign fsm_state = state;

  exec_timeout_ctr #(
    .TIMEOUT(EXEC_TIMEOUT),
    .W      (TO_W)
  ) u_timeout (
    .clk    (clk),
    .reset  (reset),
    .clear  (ctr_clear),
    .enable (ctr_en),
    .expired(ctr_expired)
  );

  // Outputs are registered, so every pulse is computed one state ahead: it is
  // decided on the transition into the state where it must be visible. JZ
  // therefore samples zero_flag on the DECODE->EXEC edge, letting the PC see
  // jump/pc_enable during EXEC and the next FETCH read the new address.
  always_comb begin
    state_nxt      = state;
    alu_valid_nxt  = 1'b0;
    unit_start_nxt = 1'b0;
    reg_we_nxt     = 1'b0;
    pc_enable_nxt  = 1'b0;
    jump_nxt       = 1'b0;
    ctr_clear      = 1'b0;
    ctr_en         = 1'b0;
    case (state)
      ST_IDLE:   if (start) state_nxt = ST_FETCH;
      ST_FETCH:  state_nxt = ST_DECODE;
      ST_DECODE: begin
        if (is_alu_op(opcode)) begin
          state_nxt     = ST_EXEC;
          alu_valid_nxt = (opcode != OP_NOP);
        end else if (opcode == OP_SBOX) begin
          state_nxt      = ST_EXEC;
          unit_start_nxt = 1'b1;
        end else if (opcode == OP_JMP) begin
          state_nxt = ST_EXEC;
          jump_nxt  = 1'b1;
        end else if (opcode == OP_JZ) begin
          state_nxt     = ST_EXEC;
          jump_nxt      = zero_flag;
          pc_enable_nxt = !zero_flag;
        end else if (opcode == OP_HALT) begin
          state_nxt = ST_HALT;
        end else begin
          state_nxt = ST_ERR;
        end
      end
      ST_EXEC: begin
        if (is_alu_op(opcode)) begin
          state_nxt     = ST_WB;
          reg_we_nxt    = (opcode != OP_NOP);
          pc_enable_nxt = 1'b1;
        end else if (opcode == OP_SBOX) begin
          state_nxt = ST_WAIT;
          ctr_clear = 1'b1;
        end else begin
          state_nxt = COMMIT_ST;
        end
      end
      ST_WAIT: begin
        if (unit_done) begin
          state_nxt     = ST_WB;
          reg_we_nxt    = 1'b1;
          pc_enable_nxt = 1'b1;
        end else begin
          ctr_en = 1'b1;
          if (ctr_expired) state_nxt = ST_ERR;
        end
      end
      ST_WB:   state_nxt = COMMIT_ST;
`ifdef CTRL_SINGLE_STEP_EN
      ST_STEP: if (step) state_nxt = ST_FETCH;
`endif
      ST_HALT: state_nxt = ST_HALT;
      ST_ERR:  state_nxt = ST_ERR;
      default: state_nxt = ST_ERR;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= ST_IDLE;
      ir          <= '0;
      pc_enable   <= 1'b0;
      jump        <= 1'b0;
      jump_addr   <= '0;
      alu_op      <= '0;
      alu_operand <= '0;
      alu_valid   <= 1'b0;
      unit_start  <= 1'b0;
      reg_we      <= 1'b0;
      busy        <= 1'b0;
      halted      <= 1'b0;
      error       <= 1'b0;
    end else begin
      state      <= state_nxt;
      alu_valid  <= alu_valid_nxt;
      unit_start <= unit_start_nxt;
      reg_we     <= reg_we_nxt;
      pc_enable  <= pc_enable_nxt;
      jump       <= jump_nxt;
      if (state == ST_FETCH) ir <= instr;
      if (state == ST_DECODE) begin
        alu_op      <= opcode;
        alu_operand <= operand;
        jump_addr   <= ADDR_W'(operand);
      end
      busy   <= (state_nxt inside {ST_FETCH, ST_DECODE, ST_EXEC, ST_WAIT, ST_WB});
      halted <= (state_nxt == ST_HALT);
      error  <= (state_nxt == ST_ERR);
    end
  end

endmodule
